// File: rtl/zvc_pkg.sv
// Shared widths, state encoding and helpers for the zero-value-compressor line packer.
package zvc_pkg;

    localparam int WORD_WIDTH     = 8;
    localparam int LINE_SIZE      = 32;
    localparam int DIST_WIDTH     = 7;
    localparam int MAX_LIFM_RSIZ  = 3;
    localparam int CNT_WIDTH      = $clog2(LINE_SIZE + 1);
    localparam int MT_ENTRY_WIDTH = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int ENTRY_WIDTH    = MT_ENTRY_WIDTH + WORD_WIDTH;
    localparam int BUF_DEPTH      = 2 * LINE_SIZE;
    localparam int OCC_WIDTH      = $clog2(BUF_DEPTH);
    localparam int LINE_IDX_WIDTH = $clog2(LINE_SIZE);

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    // Beats never carry more than one line of entries.
    function automatic logic [CNT_WIDTH-1:0] clamp_cnt(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt > CNT_WIDTH'(LINE_SIZE)) ? CNT_WIDTH'(LINE_SIZE) : cnt;
    endfunction

endpackage

// File: rtl/zvc_line_packer_if.sv
// Beat-in / line-out handshake bundle of the line packer; slave is the packer side.
interface zvc_line_packer_if;
    import zvc_pkg::*;

    logic                                    in_valid;
    logic                                    in_ready;
    logic [LINE_SIZE*WORD_WIDTH-1:0]         in_lifm;
    logic [LINE_SIZE*MT_ENTRY_WIDTH-1:0]     in_mt;
    logic [CNT_WIDTH-1:0]                    in_cnt;
    logic                                    in_last;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [LINE_SIZE*WORD_WIDTH-1:0]         out_lifm;
    logic [LINE_SIZE*MT_ENTRY_WIDTH-1:0]     out_mt;
    logic [CNT_WIDTH-1:0]                    out_cnt;
    logic                                    out_last;

    modport master (
        output in_valid, in_lifm, in_mt, in_cnt, in_last, out_ready,
        input  in_ready, out_valid, out_lifm, out_mt, out_cnt, out_last
    );

    modport slave (
        input  in_valid, in_lifm, in_mt, in_cnt, in_last, out_ready,
        output in_ready, out_valid, out_lifm, out_mt, out_cnt, out_last
    );

endinterface

// File: rtl/zvc_shift_insert.sv
// Places the first cnt entries of a beat at offset occ within the two-line window.
module zvc_shift_insert
    import zvc_pkg::*;
(
    input  logic [CNT_WIDTH-1:0]                 cnt,
    input  logic [OCC_WIDTH-1:0]                 occ,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]      lifm,
    input  logic [LINE_SIZE*MT_ENTRY_WIDTH-1:0]  mt,
    output logic [ENTRY_WIDTH-1:0]               wdata [BUF_DEPTH],
    output logic [BUF_DEPTH-1:0]                 wmask
);

    localparam int IDX_WIDTH = OCC_WIDTH + 1;

    logic [ENTRY_WIDTH-1:0] src [LINE_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < LINE_SIZE; gi++) begin : g_src
            assign src[gi] = {mt[gi*MT_ENTRY_WIDTH +: MT_ENTRY_WIDTH],
                              lifm[gi*WORD_WIDTH +: WORD_WIDTH]};
        end

        // Slot gi takes source entry gi-occ when that entry lies inside the valid prefix.
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            logic [IDX_WIDTH-1:0] rel;
            assign rel       = IDX_WIDTH'(gi) - IDX_WIDTH'(occ);
            assign wmask[gi] = (IDX_WIDTH'(gi) >= IDX_WIDTH'(occ)) && (rel < IDX_WIDTH'(cnt));
            assign wdata[gi] = wmask[gi] ? src[rel[LINE_IDX_WIDTH-1:0]] : '0;
        end
    endgenerate

endmodule

// File: rtl/zvc_line_packer.sv
// Packs variable-length compressed beats into dense LINE_SIZE-entry lines, flushing on in_last.
// Optional ZVC_LINE_PACKER_STATS_EN adds stat_words / stat_lines counters.
module zvc_line_packer
    import zvc_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    zvc_line_packer_if.slave bus
`ifdef ZVC_LINE_PACKER_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [31:0]      stat_lines
`endif
);

    logic [ENTRY_WIDTH-1:0] buf_reg [BUF_DEPTH];
    logic [ENTRY_WIDTH-1:0] wdata [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]   wmask;
    logic [OCC_WIDTH-1:0]   occ_reg, occ_next;
    pack_state_t            state_reg, state_next;
    logic                   in_ready_reg, in_ready_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   out_last_reg, out_last_next;
    logic [CNT_WIDTH-1:0]   out_cnt_reg, out_cnt_next;
    logic [CNT_WIDTH-1:0]   cnt_clamped;
    logic                   accept, pop;

    zvc_shift_insert u_shift_insert (
        .cnt   (cnt_clamped),
        .occ   (occ_reg),
        .lifm  (bus.in_lifm),
        .mt    (bus.in_mt),
        .wdata (wdata),
        .wmask (wmask)
    );

    // Handshake outputs are registered, computed from the post-update occupancy and state.
    always_comb begin
        cnt_clamped = clamp_cnt(bus.in_cnt);
        accept      = bus.in_valid && in_ready_reg;
        pop         = out_valid_reg && bus.out_ready;
        state_next  = state_reg;
        occ_next    = occ_reg;
        if (accept) begin
            occ_next = occ_reg + OCC_WIDTH'(cnt_clamped);
            if (bus.in_last) begin
                state_next = FLUSH;
            end
        end
        if (pop) begin
            occ_next = (occ_reg >= OCC_WIDTH'(LINE_SIZE)) ? occ_reg - OCC_WIDTH'(LINE_SIZE) : '0;
            if (state_reg == FLUSH && out_last_reg) begin
                state_next = FILL;
            end
        end
        if (state_next == FILL) begin
            in_ready_next  = (occ_next < OCC_WIDTH'(LINE_SIZE));
            out_valid_next = (occ_next >= OCC_WIDTH'(LINE_SIZE));
            out_last_next  = 1'b0;
        end else begin
            in_ready_next  = 1'b0;
            out_valid_next = 1'b1;
            out_last_next  = (occ_next <= OCC_WIDTH'(LINE_SIZE));
        end
        if (!out_valid_next) begin
            out_cnt_next = '0;
        end else if (occ_next >= OCC_WIDTH'(LINE_SIZE)) begin
            out_cnt_next = CNT_WIDTH'(LINE_SIZE);
        end else begin
            out_cnt_next = CNT_WIDTH'(occ_next);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= FILL;
            occ_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            occ_reg       <= occ_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_cnt_reg   <= out_cnt_next;
        end
    end

    // Accept and pop are mutually exclusive, so one update path per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_reg[i] <= '0;
            end
        end else if (pop) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_reg[i] <= (i < LINE_SIZE) ? buf_reg[(i + LINE_SIZE) % BUF_DEPTH] : '0;
            end
        end else if (accept) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (wmask[i]) begin
                    buf_reg[i] <= wdata[i];
                end
            end
        end
    end

    logic [LINE_SIZE*WORD_WIDTH-1:0]     out_lifm_c;
    logic [LINE_SIZE*MT_ENTRY_WIDTH-1:0] out_mt_c;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_SIZE; gi++) begin : g_out
            logic keep;
            assign keep = (CNT_WIDTH'(gi) < out_cnt_reg);
            assign out_lifm_c[gi*WORD_WIDTH +: WORD_WIDTH] =
                keep ? buf_reg[gi][WORD_WIDTH-1:0] : '0;
            assign out_mt_c[gi*MT_ENTRY_WIDTH +: MT_ENTRY_WIDTH] =
                keep ? buf_reg[gi][ENTRY_WIDTH-1:WORD_WIDTH] : '0;
        end
    endgenerate

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_cnt   = out_cnt_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_lifm  = out_lifm_c;
    assign bus.out_mt    = out_mt_c;

`ifdef ZVC_LINE_PACKER_STATS_EN
    logic [31:0] stat_words_reg, stat_lines_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words_reg <= '0;
            stat_lines_reg <= '0;
        end else begin
            if (accept) begin
                stat_words_reg <= stat_words_reg + 32'(cnt_clamped);
            end
            if (pop) begin
                stat_lines_reg <= stat_lines_reg + 32'd1;
            end
        end
    end

    assign stat_words = stat_words_reg;
    assign stat_lines = stat_lines_reg;
`endif

endmodule

// File: tb/tb_zvc_line_packer.sv
// Self-checking bench for zvc_line_packer: vector table plus latency, backpressure and reset sequences.
module tb_zvc_line_packer;
    import zvc_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    zvc_line_packer_if bus();

`ifdef ZVC_LINE_PACKER_STATS_EN
    logic [31:0] stat_words, stat_lines;
`endif

    zvc_line_packer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef ZVC_LINE_PACKER_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_lines (stat_lines)
`endif
    );

    typedef struct {
        int cnt;
        bit last;
    } line_t;

    typedef struct packed {
        logic [2:0]      nb;
        logic [4:0][5:0] cnt;
        logic [1:0]      nl;
        logic [1:0][5:0] lcnt;
        logic [1:0]      llast;
    } vec_t;

    line_t                  exp_lines[$];
    logic [ENTRY_WIDTH-1:0] exp_data[$];
    int n_cmp = 0;
    int n_err = 0;
    int seq = 0;
    int words_acc = 0;
    int lines_popped = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int nb, input int c0, input int c1, input int c2,
                                input int c3, input int c4, input int nl,
                                input int l0c, input bit l0l, input int l1c, input bit l1l);
        vec_t v;
        v.nb = 3'(nb);
        v.cnt[0] = 6'(c0); v.cnt[1] = 6'(c1); v.cnt[2] = 6'(c2);
        v.cnt[3] = 6'(c3); v.cnt[4] = 6'(c4);
        v.nl = 2'(nl);
        v.lcnt[0] = 6'(l0c); v.lcnt[1] = 6'(l1c);
        v.llast[0] = l0l; v.llast[1] = l1l;
        return v;
    endfunction

    function automatic void expect_line(input int cnt, input bit last);
        line_t l;
        l.cnt = cnt;
        l.last = last;
        exp_lines.push_back(l);
    endfunction

    // Drives one beat, holds it until accepted, and records the clamped entries it carries.
    task automatic send_beat(input int cnt, input bit last);
        int n;
        int guard;
        n = (cnt > LINE_SIZE) ? LINE_SIZE : cnt;
        bus.in_cnt  = CNT_WIDTH'(cnt);
        bus.in_last = last;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (i < n) begin
                bus.in_lifm[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(seq + i);
                bus.in_mt[i*MT_ENTRY_WIDTH +: MT_ENTRY_WIDTH] = MT_ENTRY_WIDTH'((seq + i) * 37 + 5);
            end else begin
                bus.in_lifm[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'($urandom);
                bus.in_mt[i*MT_ENTRY_WIDTH +: MT_ENTRY_WIDTH] = MT_ENTRY_WIDTH'($urandom);
            end
        end
        bus.in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_data.push_back({MT_ENTRY_WIDTH'((seq + i) * 37 + 5), WORD_WIDTH'(seq + i)});
        end
        seq += n;
        words_acc += n;
        $display("beat: cnt=%0d last=%0d accepted", cnt, last);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int g = 0; g < 300 && exp_lines.size() != 0; g++) begin
            @(posedge clk);
        end
        #1;
        check({name, "_lines_left"}, 64'(exp_lines.size()), 64'd0);
        check({name, "_data_left"}, 64'(exp_data.size()), 64'd0);
    endtask

    // Scoreboard: every popped line is compared against the oldest expected line and entries.
    initial begin
        line_t l;
        logic [ENTRY_WIDTH-1:0] got, exp;
        bit ok;
        int bad_idx;
        logic [ENTRY_WIDTH-1:0] bad_got, bad_exp;
        forever begin
            @(negedge clk);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                lines_popped++;
                if (exp_lines.size() == 0) begin
                    check("unexpected_line", 64'(bus.out_cnt), 64'hFFFF);
                end else begin
                    l = exp_lines.pop_front();
                    $display("line: out_cnt=%0d out_last=%0d (expect %0d/%0d)",
                             bus.out_cnt, bus.out_last, l.cnt, l.last);
                    check("out_cnt", 64'(bus.out_cnt), 64'(l.cnt));
                    check("out_last", 64'(bus.out_last), 64'(l.last));
                    ok = 1'b1;
                    bad_idx = 0;
                    bad_got = '0;
                    bad_exp = '0;
                    for (int i = 0; i < LINE_SIZE; i++) begin
                        got = {bus.out_mt[i*MT_ENTRY_WIDTH +: MT_ENTRY_WIDTH],
                               bus.out_lifm[i*WORD_WIDTH +: WORD_WIDTH]};
                        if (i < l.cnt && exp_data.size() != 0) exp = exp_data.pop_front();
                        else if (i < l.cnt) exp = '1;
                        else exp = '0;
                        if (ok && got !== exp) begin
                            ok = 1'b0;
                            bad_idx = i;
                            bad_got = got;
                            bad_exp = exp;
                        end
                    end
                    n_cmp++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL line_data entry %0d: got %0h expected %0h", bad_idx, bad_got, bad_exp);
                    end
                end
            end
        end
    end

    vec_t vecs [8];

    initial begin
        logic [LINE_SIZE*WORD_WIDTH-1:0]     snap_l;
        logic [LINE_SIZE*MT_ENTRY_WIDTH-1:0] snap_m;
        int guard;

        vecs[0] = mk(5,  8,  8,  8, 8, 0, 2, 32, 0,  0, 1);
        vecs[1] = mk(3, 20, 20,  0, 0, 0, 2, 32, 0,  8, 1);
        vecs[2] = mk(2,  5,  3,  0, 0, 0, 1,  8, 1,  0, 0);
        vecs[3] = mk(1,  0,  0,  0, 0, 0, 1,  0, 1,  0, 0);
        vecs[4] = mk(2, 40, 31,  0, 0, 0, 2, 32, 0, 31, 1);
        vecs[5] = mk(2, 31, 32,  0, 0, 0, 2, 32, 0, 31, 1);
        vecs[6] = mk(1, 32,  0,  0, 0, 0, 1, 32, 1,  0, 0);
        vecs[7] = mk(3,  1, 63,  2, 0, 0, 2, 32, 0,  3, 1);

        bus.in_valid = 1'b0;
        bus.in_lifm = '0;
        bus.in_mt = '0;
        bus.in_cnt = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_cnt", 64'(bus.out_cnt), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        // Vector table
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < int'(vecs[v].nl); k++) begin
                expect_line(int'(vecs[v].lcnt[k]), vecs[v].llast[k]);
            end
            for (int b = 0; b < int'(vecs[v].nb); b++) begin
                send_beat(int'(vecs[v].cnt[b]), b == int'(vecs[v].nb) - 1);
            end
            wait_drain($sformatf("vec%0d", v));
        end

        // Latency: out_valid rises the cycle after the beat that completes a line
        expect_line(32, 0);
        expect_line(0, 1);
        send_beat(8, 0);
        send_beat(8, 0);
        send_beat(8, 0);
        check("lat_no_valid_early", 64'(bus.out_valid), 64'd0);
        send_beat(8, 0);
        @(negedge clk);
        check("lat_valid_next_cycle", 64'(bus.out_valid), 64'd1);
        send_beat(0, 1);
        wait_drain("latency");

        // Backpressure: hold a full line for 10 cycles
        bus.out_ready = 1'b0;
        expect_line(32, 0);
        expect_line(8, 1);
        send_beat(20, 0);
        send_beat(20, 0);
        @(negedge clk);
        snap_l = bus.out_lifm;
        snap_m = bus.out_mt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_out_cnt", 64'(bus.out_cnt), 64'd32);
            check("hold_data_changed", 64'(bus.out_lifm != snap_l || bus.out_mt != snap_m), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("in_ready_after_pop", 64'(bus.in_ready), 64'd1);
        send_beat(0, 1);
        wait_drain("backpressure");

        // Reset mid-drain with 40 entries held
        bus.out_ready = 1'b0;
        send_beat(20, 0);
        send_beat(20, 0);
        @(negedge clk);
        check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_out_cnt", 64'(bus.out_cnt), 64'd0);
        exp_data.delete();
        exp_lines.delete();
        words_acc = 0;
        lines_popped = 0;
`ifdef ZVC_LINE_PACKER_STATS_EN
        check("reset_stat_words", 64'(stat_words), 64'd0);
        check("reset_stat_lines", 64'(stat_lines), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        expect_line(8, 1);
        send_beat(5, 0);
        send_beat(3, 1);
        wait_drain("post_reset");

`ifdef ZVC_LINE_PACKER_STATS_EN
        check("stat_words", 64'(stat_words), 64'(words_acc));
        check("stat_lines", 64'(stat_lines), 64'(lines_popped));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
